// File: rtl/pdp8_binload_pkg.sv
// pdp8_binload_defs: shared encodings and loader register set for the BIN tape loader
package pdp8_binload_defs;
  typedef enum logic [2:0] {IDLE, SEEK, LEADER, FRAMES, LO, WRITE, FINISH} state_t;
  typedef enum logic [2:0] {C_LEADER, C_RUBOUT, C_FIELD, C_ORIGIN, C_DATA, C_IGNORE} cls_t;
  localparam logic [7:0] B_LEADER = 8'o200;
  localparam logic [7:0] B_RUBOUT = 8'o377;
  localparam logic [7:0] M_ORIGIN = 8'o100;
  localparam logic [7:0] M_FIELD  = 8'o300;
  typedef struct packed {
    state_t      state;
    logic [2:0]  field;
    logic [11:0] origin;
    logic [11:0] sum;
    logic        pend_v;
    logic [11:0] pend_word;
    logic [14:0] pend_addr;
    logic [7:0]  hi;
    logic        req;
    logic [14:0] ma;
    logic [11:0] dout;
    logic        done;
    logic        cksum_err;
    logic        fmt_err;
    logic [14:0] count;
  } regs_t;
endpackage

// File: rtl/pdp8_binload_classify.sv
// pdp8_binload_classify: combinational BIN tape byte classifier
module pdp8_binload_classify
  import pdp8_binload_defs::*;
(
  input  logic [7:0] b,
  output cls_t       cls
);
  always_comb
    cls = b == B_LEADER ? C_LEADER :
          b == B_RUBOUT ? C_RUBOUT :
          (b & M_FIELD) == M_FIELD ? (b[2:0] == 3'd0 ? C_FIELD : C_IGNORE) :
          (b & M_FIELD) == M_ORIGIN ? C_ORIGIN :
          (b & M_FIELD) == 8'd0 ? C_DATA : C_IGNORE;
endmodule

// File: rtl/pdp8_binload.sv
// pdp8_binload: BIN paper-tape loader depositing words into memory via the ext-RAM handshake
module pdp8_binload
  import pdp8_binload_defs::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_write_req,
  output logic [ADDR_W-1:0] ram_ma,
  output logic [11:0]       ram_out,
  input  logic              ram_done,
  output logic              busy,
  output logic              done,
  output logic              cksum_err,
  output logic              fmt_err,
  output logic [ADDR_W-1:0] word_count
);
  regs_t r, n;
  cls_t cls;
  logic acc;
  logic trailer;
  logic [11:0] word;
  pdp8_binload_classify u_cls (.b(in_data), .cls(cls));
  assign in_ready = (r.state inside {SEEK, LEADER, FRAMES, LO}) && !r.req;
  assign acc = in_valid && in_ready;
  assign trailer = cls == C_LEADER && r.state == FRAMES;
  assign word = {r.hi[5:0], in_data[5:0]};
  always_comb begin
    n = r;
    case (r.state)
      IDLE: if (start) begin
        n = '0;
        n.state = SEEK;
      end
      SEEK: if (acc && cls == C_LEADER) n.state = LEADER;
      LEADER, FRAMES: if (acc) begin
        n.state = trailer ? FINISH : cls == C_LEADER ? LEADER :
                  (cls == C_ORIGIN || cls == C_DATA) ? LO : FRAMES;
        n.hi = in_data;
        n.field = cls == C_FIELD ? in_data[5:3] : r.field;
        n.done = r.done || trailer;
        n.cksum_err = trailer ? (!r.pend_v || r.pend_word != r.sum) : r.cksum_err;
      end
      LO: if (acc && cls != C_RUBOUT) begin
        if (in_data[7:6] != 2'b00) begin
          n.fmt_err = 1'b1;
          n.done = 1'b1;
          n.state = IDLE;
        end else begin
          // the previous word is only committed once we know it was not the checksum
          if (r.pend_v) begin
            n.sum = n.sum + 12'(r.pend_word[11:6]) + 12'(r.pend_word[5:0]);
            n.req = 1'b1;
            n.ma = r.pend_addr;
            n.dout = r.pend_word;
            n.count = r.count + 15'd1;
            n.pend_v = 1'b0;
          end
          if (r.hi[6]) begin
            n.sum = n.sum + 12'(r.hi) + 12'(in_data);
            n.origin = word;
          end else begin
            n.pend_v = 1'b1;
            n.pend_word = word;
            n.pend_addr = {r.field, r.origin};
            n.origin = r.origin + 12'd1;
          end
          n.state = r.pend_v ? WRITE : FRAMES;
        end
      end
      WRITE: if (ram_done) begin
        n.req = 1'b0;
        n.state = FRAMES;
      end
      FINISH: n.state = IDLE;
      default: n.state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) r <= '0;
    else r <= n;
  assign ram_write_req = r.req;
  assign ram_ma = ADDR_W'(r.ma);
  assign ram_out = r.dout;
  assign busy = r.state != IDLE && r.state != FINISH;
  assign done = r.done;
  assign cksum_err = r.cksum_err;
  assign fmt_err = r.fmt_err;
  assign word_count = ADDR_W'(r.count);
endmodule

// File: doc/pdp8_binload.md
# pdp8_binload

Hardware BIN-format paper-tape loader for the pdp8 core. It consumes a byte stream, decodes leader/trailer, field, origin and data frames, and deposits each data word into main memory. Writes go through the same external-RAM request handshake (`ext_ram_*`) the I/O subsystem uses, so the top level can load a program before releasing the CPU at `starting_pc`. It verifies the tape checksum and reports completion, checksum and format status.

## Interface
Parameters:
- `ADDR_W`, 15: memory address width, as 3-bit field plus 12-bit address.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse that arms the loader; ignored while busy.
- `in_data`  in  8: tape byte, interpreted as octal 0000–0377.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: byte is accepted on a cycle with `in_valid & in_ready`.
- `ram_write_req`  out  1: write request to memory.
- `ram_ma`  out  15: write address.
- `ram_out`  out  12: write data.
- `ram_done`  in  1: one-cycle acknowledge from memory.
- `busy`  out  1: loader is armed and not finished.
- `done`  out  1: trailer was reached; sticky until the next `start`.
- `cksum_err`  out  1: checksum mismatch, or no checksum word at trailer; sticky.
- `fmt_err`  out  1: illegal low byte; sticky; terminates the load.
- `word_count`  out  15: number of data words written.

## Operation
- Reset: state IDLE. All outputs 0. Field, origin, sum and pending word are cleared.
- IDLE: `in_ready`=0. On `start`, clear status, `word_count`, field, origin and sum, then enter SEEK.
- SEEK: accept and discard bytes until 0200. On 0200, enter LEADER.
- LEADER: 0200 bytes are consumed. The first other byte is classified as a frame byte, and the loader enters FRAMES.
- Byte classification in FRAMES/HI:
  - 0200: trailer, go to FINISH.
  - 0377: rubout, ignored.
  - 03x0 (bits 2:0 = 0): field setting; field ← bits 5:3. Not summed.
  - Other 03xx: ignored.
  - 01xxxxxx: origin-high.
  - 00xxxxxx: data-high.
- LO state: the next non-rubout byte must have bits 7:6 = 00. Otherwise set `fmt_err`, `done`=1, go to IDLE with `busy`=0.
- Origin frame complete: add both bytes to sum, flush the pending word (see WRITE), then origin ← {hi[5:0], lo[5:0]}.
- Data frame complete: flush the pending word if one exists. Then pending ← {field, origin, word}, remember its byte pair, and increment origin (12-bit wrap, field unchanged).
- Flush: add the pending word's two bytes to sum, write it, clear pending, increment `word_count`.
- The last data frame before trailer is the checksum and is never written.
- FINISH:
  - If no word is pending, set `cksum_err`.
  - Otherwise set `cksum_err` = (pending word ≠ sum[11:0]).
  - Then `done`=1, `busy`=0, go to IDLE.
- Sum is the 12-bit wrap-around sum of 8-bit byte values of origin and committed data frames.
- Field setting is captured per word. A field byte between data frames does not affect the already-pending word.

## Timing
- One byte is accepted per cycle at most.
- `in_ready`=1 in SEEK/LEADER/FRAMES/LO when no write is outstanding.
- WRITE:
  - `ram_write_req`, `ram_ma`, `ram_out` assert on the cycle after the completing low byte.
  - All three hold stable until the cycle `ram_done`=1.
  - `ram_write_req` deasserts the following cycle.
  - `in_ready`=0 from the completing byte until that deassert cycle.
- The next byte can be accepted the cycle after `ram_write_req` falls. Minimum write turnaround is 2 cycles when `ram_done` returns the cycle after req.
- `ram_done` while `ram_write_req`=0 is ignored.
- `start` while busy is ignored.
- `reset` mid-write drops `ram_write_req` on the next edge. No further writes occur.
- `done`/`cksum_err`/`fmt_err` update on the cycle after the trailer or faulting byte is accepted.

## Structure
- Shared package `pdp8_binload_defs`:
  - state encoding IDLE/SEEK/LEADER/FRAMES/LO/WRITE/FINISH;
  - byte constants LEADER=0200, RUBOUT=0377;
  - class masks ORIGIN=0100, FIELD=0300.
- One sub-module, `pdp8_binload_classify`: combinational byte classifier (leader, rubout, field, origin-high, data-high, ignore). It is instantiated once.
- The FSM, pending register, sum and write handshake live in `pdp8_binload`.

## Test plan
- Basic load:
  - Stimulus: start; 0200×4, 0102 0000, 0073 0000, 0074 0002, 0002 0073, 0200; `ram_done` returned 1 cycle after req.
  - Required: writes 00200←7300 and 00201←7402; `done`=1, `cksum_err`=0, `word_count`=2.
- Field setting: same tape with 0320 before the origin → writes to 20200/20201. Checksum is unchanged and passes.
- Bad checksum: checksum bytes 0002 0074 → the same two writes occur, `done`=1, `cksum_err`=1.
- Slow memory:
  - Stimulus: `ram_done` delayed 5 cycles; `in_valid` held high.
  - Required: `in_ready`=0 and req/ma/data stable throughout. No byte is lost.
- Format error: data-high 0073 followed by 0101 → `fmt_err`=1, no write, `busy`=0.
- Reset mid-write: assert `reset` while req is high → next cycle all outputs are 0 and state is IDLE. A later `start` plus the basic tape loads correctly.
